// File: rtl/board_guess_checker.sv
// Board guess checker: shows a target board, then scores player tile picks until win or loss.
// Optional feature macro: CHECKER_SCORE_EN (builds a saturating hit score register).
module board_guess_checker #(
  parameter int unsigned N_TILES     = 8,
  parameter int unsigned MAX_WRONG   = 3,
  parameter int unsigned SHOW_CYCLES = 16,
  localparam int unsigned IDX_W      = $clog2(N_TILES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_TILES-1:0] board,
  input  logic               board_valid,
  input  logic [IDX_W-1:0]   select_idx,
  input  logic               select_valid,
  input  logic               start,
  output logic [N_TILES-1:0] display,
  output logic               ready,
  output logic               playing,
  output logic               hit,
  output logic               miss,
  output logic [3:0]         wrong_cnt,
  output logic               win,
  output logic               lose,
  output logic [7:0]         score
);

  localparam int unsigned TIMER_W = $clog2(SHOW_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHOW,
    S_PLAY,
    S_WIN,
    S_LOSE
  } state_t;

  state_t             state_q, state_d;
  logic [N_TILES-1:0] target_q, target_d;
  logic [N_TILES-1:0] found_q, found_d;
  logic [N_TILES-1:0] display_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         wrong_d;
  logic               hit_d, miss_d;
  logic               sel_in_range;

  assign sel_in_range = 32'(select_idx) < N_TILES;

  // Next-state and next-output decode; outputs are registered from these values.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    found_d  = found_q;
    timer_d  = timer_q;
    wrong_d  = wrong_cnt;
    hit_d    = 1'b0;
    miss_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (board_valid && (board != '0)) begin
          target_d = board;
          timer_d  = TIMER_W'(SHOW_CYCLES - 1);
          state_d  = S_SHOW;
        end
      end
      S_SHOW: begin
        if (timer_q == '0) begin
          found_d = '0;
          wrong_d = 4'd0;
          state_d = S_PLAY;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      S_PLAY: begin
        if (select_valid && sel_in_range) begin
          if (target_q[select_idx]) begin
            // A repeat pick of an already-found tile is neither rewarded nor penalised.
            if (!found_q[select_idx]) begin
              found_d[select_idx] = 1'b1;
              hit_d               = 1'b1;
            end
          end else begin
            wrong_d = wrong_cnt + 4'd1;
            miss_d  = 1'b1;
          end
          if (found_d == target_q) begin
            state_d = S_WIN;
          end else if (wrong_d == 4'(MAX_WRONG)) begin
            state_d = S_LOSE;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (start) begin
          found_d = '0;
          wrong_d = 4'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_SHOW, S_WIN, S_LOSE: display_d = target_d;
      S_PLAY:                display_d = found_d;
      default:               display_d = '0;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      target_q  <= '0;
      found_q   <= '0;
      timer_q   <= '0;
      wrong_cnt <= 4'd0;
      display   <= '0;
      ready     <= 1'b1;
      playing   <= 1'b0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      found_q   <= found_d;
      timer_q   <= timer_d;
      wrong_cnt <= wrong_d;
      display   <= display_d;
      ready     <= (state_d == S_IDLE);
      playing   <= (state_d == S_PLAY);
      hit       <= hit_d;
      miss      <= miss_d;
      win       <= (state_d == S_WIN);
      lose      <= (state_d == S_LOSE);
    end
  end

`ifdef CHECKER_SCORE_EN
  // Score survives across rounds; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score <= 8'd0;
    end else if (hit_d && (score != 8'hFF)) begin
      score <= score + 8'd1;
    end
  end
`else
  assign score = 8'd0;
`endif

endmodule

// File: tb/tb_board_guess_checker.sv
// Scoreboard bench for board_guess_checker: directed rounds plus randomized rounds vs a set-based model.
module tb_board_guess_checker;
  localparam int unsigned N  = 8;
  localparam int unsigned MW = 3;
  localparam int unsigned SC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] board;
  logic       board_valid;
  logic [2:0] select_idx;
  logic       select_valid;
  logic       start;
  logic [7:0] display;
  logic       ready, playing, hit, miss, win, lose;
  logic [3:0] wrong_cnt;
  logic [7:0] score;

  board_guess_checker #(.N_TILES(N), .MAX_WRONG(MW), .SHOW_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .board(board), .board_valid(board_valid),
    .select_idx(select_idx), .select_valid(select_valid), .start(start),
    .display(display), .ready(ready), .playing(playing), .hit(hit), .miss(miss),
    .wrong_cnt(wrong_cnt), .win(win), .lose(lose), .score(score)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_hit;
    logic [7:0] disp;
    logic [3:0] wc;
    logic [7:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: target set, found set, miss count, persistent score.
  bit   tgt_m[8];
  bit   fnd_m[8];
  int   wrong_m;
  int   score_m;

  function automatic logic [7:0] pack_set(input bit s[8]);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = s[i];
    return v;
  endfunction

  function automatic bit all_found();
    for (int i = 0; i < 8; i++) if (tgt_m[i] && !fnd_m[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every hit/miss pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (!reset && (hit || miss)) begin
      exp_t e;
      check("pulse_exclusive", 32'(hit && miss), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, hit, miss}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 32'(hit), 32'(e.is_hit));
        check("pulse_display", 32'(display), 32'(e.disp));
        check("pulse_wrong_cnt", 32'(wrong_cnt), 32'(e.wc));
        check("pulse_score", 32'(score), 32'(e.sc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_display"}, 32'(display), 32'd0);
    check({tag, "_winlose"}, {30'd0, win, lose}, 32'd0);
    check({tag, "_wrong_cnt"}, 32'(wrong_cnt), 32'd0);
    check({tag, "_playing"}, 32'(playing), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    board_valid = 1'b0; select_valid = 1'b0; start = 1'b0; board = 8'd0; select_idx = 3'd0;
    #3;
    for (int i = 0; i < 8; i++) begin tgt_m[i] = 1'b0; fnd_m[i] = 1'b0; end
    wrong_m = 0;
    score_m = 0;
    exp_q.delete();
    idle_checks("reset");
    check("reset_score", 32'(score), 32'd0);
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic load_board(input logic [7:0] b);
    int n;
    bit disp_ok;
    board = b;
    board_valid = 1'b1;
    tick();
    board_valid = 1'b0;
    if (b == 8'd0) begin
      check("zero_board_ready", 32'(ready), 32'd1);
      check("zero_board_display", 32'(display), 32'd0);
      return;
    end
    for (int i = 0; i < 8; i++) begin tgt_m[i] = b[i]; fnd_m[i] = 1'b0; end
    wrong_m = 0;
    check("show_ready_low", 32'(ready), 32'd0);
    n = 0;
    disp_ok = 1'b1;
    while (!playing && n < 50) begin
      if (display !== b) disp_ok = 1'b0;
      n++;
      tick();
    end
    check("show_length", 32'(n), 32'(SC));
    check("show_display_hold", 32'(disp_ok), 32'd1);
    check("play_display_empty", 32'(display), 32'd0);
  endtask

  task automatic do_select(input logic [2:0] idx);
    exp_t e;
    bit won, lost;
    select_idx = idx;
    select_valid = 1'b1;
    if (tgt_m[idx] && !fnd_m[idx]) begin
      fnd_m[idx] = 1'b1;
`ifdef CHECKER_SCORE_EN
      if (score_m < 255) score_m++;
`endif
      e.is_hit = 1'b1;
    end else if (!tgt_m[idx]) begin
      wrong_m++;
      e.is_hit = 1'b0;
    end
    won  = all_found();
    lost = !won && (wrong_m == MW);
    if (tgt_m[idx] == 1'b0 || e.is_hit) begin
      e.disp = lost ? pack_set(tgt_m) : pack_set(fnd_m);
      e.wc   = 4'(wrong_m);
      e.sc   = 8'(score_m);
      if (!(tgt_m[idx] && !e.is_hit)) exp_q.push_back(e);
    end
    tick();
    select_valid = 1'b0;
    check("after_select_win", 32'(win), 32'(won));
    check("after_select_lose", 32'(lose), 32'(lost));
    check("after_select_wrong_cnt", 32'(wrong_cnt), 32'(wrong_m));
  endtask

  task automatic finish_round();
    start = 1'b1;
    tick();
    start = 1'b0;
    idle_checks("restart");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [2:0] idx;
    int         sel_n;

    do_reset();

    // Winning round.
    load_board(8'hA5);
    do_select(3'd0);
    do_select(3'd2);
    do_select(3'd5);
    do_select(3'd7);
    check("win_display", 32'(display), 32'hA5);
`ifdef CHECKER_SCORE_EN
    check("win_score", 32'(score), 32'd4);
`else
    check("win_score", 32'(score), 32'd0);
`endif
    finish_round();

    // Losing round.
    load_board(8'hA5);
    do_select(3'd1);
    do_select(3'd3);
    do_select(3'd4);
    check("lose_display", 32'(display), 32'hA5);
    tick();
    check("lose_wrong_hold", 32'(wrong_cnt), 32'd3);
    finish_round();

    // Repeat pick gives no pulse and no penalty; then start with board_valid together.
    load_board(8'hA5);
    do_select(3'd0);
    do_select(3'd0);
    check("repeat_wrong_cnt", 32'(wrong_cnt), 32'd0);
    do_select(3'd2);
    do_select(3'd5);
    do_select(3'd7);
    start = 1'b1;
    board = 8'h3C;
    board_valid = 1'b1;
    tick();
    start = 1'b0;
    check("start_first_ready", 32'(ready), 32'd1);
    check("start_first_display", 32'(display), 32'd0);
    load_board(8'h3C);
    do_select(3'd2);
    do_select(3'd3);
    do_select(3'd4);
    do_select(3'd5);
    finish_round();

    // Zero board is ignored.
    load_board(8'h00);
    tick();
    check("zero_board_stays_idle", 32'(ready), 32'd1);

    // Reset in the middle of SHOW aborts at once.
    board = 8'h5A;
    board_valid = 1'b1;
    tick();
    board_valid = 1'b0;
    tick();
    do_reset();

    // Randomized rounds.
    for (int r = 0; r < 24; r++) begin
      b = 8'($urandom_range(1, 255));
      load_board(b);
      sel_n = 0;
      while (!(all_found() || wrong_m == MW) && sel_n < 64) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        idx = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 9) < 6) begin
          for (int k = 0; k < 8; k++) if (!b[idx]) idx = idx + 3'd1;
        end
        do_select(idx);
        sel_n++;
      end
      if (all_found() || wrong_m == MW) finish_round();
      else do_reset();
    end

    tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
